// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor slice.
//   ADR_WIDTH_DEF  default PC/target width
//   PC_INC         sequential fetch increment
//   cnt_*()        2-bit-style counter states generalised to any CNT_WIDTH
package branch_predictor_pkg;

  localparam int unsigned ADR_WIDTH_DEF = 32;
  localparam int unsigned PC_INC        = 4;

  // MSB set, rest clear: lowest state that still predicts taken.
  function automatic int unsigned cnt_weak_taken(int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // MSB clear, rest set: highest state that still predicts not-taken.
  function automatic int unsigned cnt_weak_nt(int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned cnt_strong_taken(int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned cnt_strong_nt(int unsigned w);
    return (w > 0) ? 32'd0 : 32'd0;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup / EX-update / statistics bundle of the branch predictor.
//   master: pipeline side (drives if_pc and the upd_* resolution fields)
//   slave : predictor side (drives prediction, redirect and statistics)
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int ADR_WIDTH  = ADR_WIDTH_DEF,
  parameter int STAT_WIDTH = 32
);
  logic [ADR_WIDTH-1:0]  if_pc;
  logic                  pred_hit;
  logic                  pred_taken;
  logic [ADR_WIDTH-1:0]  pred_next_pc;

  logic                  upd_valid;
  logic [ADR_WIDTH-1:0]  upd_pc;
  logic [ADR_WIDTH-1:0]  upd_target;
  logic [ADR_WIDTH-1:0]  upd_pred_next_pc;
  logic                  upd_taken;
  logic                  upd_pred_taken;
  logic                  mispredict;
  logic [ADR_WIDTH-1:0]  redirect_pc;

  logic [STAT_WIDTH-1:0] branch_cnt;
  logic [STAT_WIDTH-1:0] mispredict_cnt;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_target, upd_pred_next_pc, upd_taken, upd_pred_taken,
    input  pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_target, upd_pred_next_pc, upd_taken, upd_pred_taken,
    output pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down direction counter step.
//   cnt   current counter value
//   taken resolved direction (1 = count up)
//   next  updated value, clamped at 0 and all-ones
module sat_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 taken,
  output logic [CNT_WIDTH-1:0] next
);
  always_comb begin
    next = cnt;
    if (taken) begin
      if (cnt != '1) next = cnt + 1'b1;
    end else begin
      if (cnt != '0) next = cnt - 1'b1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
//   clk, rst : clock, synchronous active-low reset
//   bus      : slave side of branch_predictor_if
//              lookup  if_pc -> pred_hit/pred_taken/pred_next_pc (combinational)
//              update  upd_* -> mispredict/redirect_pc (combinational), table write on clk
//              stats   branch_cnt, mispredict_cnt (saturating)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADR_WIDTH  = ADR_WIDTH_DEF,
  parameter int ENTRIES    = 16,
  parameter int CNT_WIDTH  = 2,
  parameter int STAT_WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  branch_predictor_if.slave bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADR_WIDTH - IDX - 2;

  localparam logic [CNT_WIDTH-1:0] CNT_WNT = CNT_WIDTH'(cnt_weak_nt(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_WT  = CNT_WIDTH'(cnt_weak_taken(CNT_WIDTH));
  localparam logic [ADR_WIDTH-1:0] INC     = ADR_WIDTH'(PC_INC);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_predictor: ENTRIES must be a power of two >= 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("branch_predictor: CNT_WIDTH must be >= 1");
  end

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [ADR_WIDTH-1:0] target_q [ENTRIES];
  logic [CNT_WIDTH-1:0] cnt_q    [ENTRIES];
  logic [STAT_WIDTH-1:0] branch_cnt_q, misp_cnt_q;

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  logic [IDX-1:0]   l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;
  assign l_idx = bus.if_pc[IDX+1:2];
  assign l_tag = bus.if_pc[ADR_WIDTH-1:IDX+2];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  assign bus.pred_hit     = l_hit;
  assign bus.pred_taken   = l_hit && cnt_q[l_idx][CNT_WIDTH-1];
  assign bus.pred_next_pc = bus.pred_taken ? target_q[l_idx] : bus.if_pc + INC;

  logic [IDX-1:0]       u_idx;
  logic [TAG_W-1:0]     u_tag;
  logic                 u_hit;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  assign u_idx = bus.upd_pc[IDX+1:2];
  assign u_tag = bus.upd_pc[ADR_WIDTH-1:IDX+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .cnt   (cnt_q[u_idx]),
    .taken (bus.upd_taken),
    .next  (cnt_nxt)
  );

  // A taken branch whose direction was right can still mispredict on target.
  assign bus.mispredict  = bus.upd_valid &&
                           ((bus.upd_taken != bus.upd_pred_taken) ||
                            (bus.upd_taken && (bus.upd_target != bus.upd_pred_next_pc)));
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + INC;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= '0;
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
    end else if (bus.upd_valid) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      if (bus.mispredict && misp_cnt_q != '1) misp_cnt_q <= misp_cnt_q + 1'b1;
      if (u_hit) begin
        cnt_q[u_idx] <= cnt_nxt;
      end else if (bus.upd_taken) begin
        valid_q[u_idx] <= 1'b1;
        cnt_q[u_idx]   <= CNT_WT;
      end
    end
  end

  // Tag/target carry no reset; valid gates them.
  always_ff @(posedge clk) begin
    if (rst && bus.upd_valid && bus.upd_taken) begin
      target_q[u_idx] <= bus.upd_target;
      if (!u_hit) tag_q[u_idx] <= u_tag;
    end
  end

  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = misp_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADR_WIDTH(32), .STAT_WIDTH(4)) bus ();

  branch_predictor #(.ADR_WIDTH(32), .ENTRIES(16), .CNT_WIDTH(2), .STAT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                     input logic ptk, input logic [31:0] pnext);
    bus.upd_valid        = 1'b1;
    bus.upd_pc           = pc;
    bus.upd_target       = tgt;
    bus.upd_taken        = tk;
    bus.upd_pred_taken   = ptk;
    bus.upd_pred_next_pc = pnext;
  endtask

  task automatic idle();
    bus.upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] nxt);
    bus.if_pc = pc;
    #1;
    chk({tag, ".hit"},  32'(bus.pred_hit), 32'(hit));
    chk({tag, ".tk"},   32'(bus.pred_taken), 32'(tk));
    chk({tag, ".next"}, bus.pred_next_pc, nxt);
  endtask

  initial begin
    bus.if_pc = 32'h0040_0010;
    idle();
    upd(32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    bus.upd_valid = 1'b0;

    // Reset for two edges
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.bcnt", 32'(bus.branch_cnt), 32'd0);
    chk("rst.mcnt", 32'(bus.mispredict_cnt), 32'd0);

    // Cold lookup
    look("cold", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);

    // Allocate on taken miss, with same-cycle lookup of that index (old contents)
    @(negedge clk);
    upd(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 32'h0040_0014);
    look("rbw_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    chk("alloc.misp",  32'(bus.mispredict), 32'd1);
    chk("alloc.redir", bus.redirect_pc, 32'h0040_0100);
    @(negedge clk);
    idle();
    look("rbw_new", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    chk("alloc.bcnt", 32'(bus.branch_cnt), 32'd1);
    chk("alloc.mcnt", 32'(bus.mispredict_cnt), 32'd1);

    // Four taken updates; the fourth moves the target (target mispredict)
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      upd(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b1, 32'h0040_0100);
      #1 chk("tk.misp", 32'(bus.mispredict), 32'd0);
    end
    @(negedge clk);
    upd(32'h0040_0010, 32'h0040_0200, 1'b1, 1'b1, 32'h0040_0100);
    #1;
    chk("tgt.misp",  32'(bus.mispredict), 32'd1);
    chk("tgt.redir", bus.redirect_pc, 32'h0040_0200);
    @(negedge clk);
    idle();
    look("sat_hi", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);

    // Three not-taken: 11->10 (misp), 10->01 (misp), 01->00 (no misp)
    @(negedge clk);
    upd(32'h0040_0010, 32'h0, 1'b0, 1'b1, 32'h0040_0200);
    #1;
    chk("nt1.misp",  32'(bus.mispredict), 32'd1);
    chk("nt1.redir", bus.redirect_pc, 32'h0040_0014);
    @(negedge clk);
    upd(32'h0040_0010, 32'h0, 1'b0, 1'b1, 32'h0040_0200);
    #1 chk("nt2.misp", 32'(bus.mispredict), 32'd1);
    @(negedge clk);
    upd(32'h0040_0010, 32'h0, 1'b0, 1'b0, 32'h0040_0014);
    #1 chk("nt3.misp", 32'(bus.mispredict), 32'd0);
    @(negedge clk);
    idle();
    look("sat_lo", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    chk("sat.bcnt", 32'(bus.branch_cnt), 32'd8);
    chk("sat.mcnt", 32'(bus.mispredict_cnt), 32'd4);

    // Not-taken miss on same index: table unchanged
    @(negedge clk);
    upd(32'h0040_0090, 32'h0, 1'b0, 1'b0, 32'h0040_0094);
    #1;
    chk("ntmiss.misp",  32'(bus.mispredict), 32'd0);
    chk("ntmiss.redir", bus.redirect_pc, 32'h0040_0094);
    @(negedge clk);
    idle();
    look("ntmiss.keep", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    look("ntmiss.none", 32'h0040_0090, 1'b0, 1'b0, 32'h0040_0094);

    // Aliasing: 0x0040_0050 evicts 0x0040_0010 (both index 4)
    @(negedge clk);
    upd(32'h0040_0050, 32'h0040_0300, 1'b1, 1'b0, 32'h0040_0054);
    #1 chk("alias.misp", 32'(bus.mispredict), 32'd1);
    @(negedge clk);
    idle();
    look("alias.old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    look("alias.new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300);
    chk("alias.bcnt", 32'(bus.branch_cnt), 32'd10);

    // upd_valid low: nothing moves even with other fields active
    bus.upd_pc = 32'h0040_0050; bus.upd_taken = 1'b0; bus.upd_pred_taken = 1'b1;
    #1 chk("idle.misp", 32'(bus.mispredict), 32'd0);
    @(negedge clk);
    look("idle.keep", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300);
    chk("idle.bcnt", 32'(bus.branch_cnt), 32'd10);

    // Ten correct predictions: 20 updates total, branch_cnt saturates at 15
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      upd(32'h0040_0050, 32'h0040_0300, 1'b1, 1'b1, 32'h0040_0300);
    end
    @(negedge clk);
    idle();
    #1;
    chk("stat.bcnt", 32'(bus.branch_cnt), 32'd15);
    chk("stat.mcnt", 32'(bus.mispredict_cnt), 32'd5);

    // One-cycle reset with a simultaneous update that must be discarded
    @(negedge clk);
    rst = 1'b0;
    upd(32'h0040_0020, 32'h0040_0400, 1'b1, 1'b0, 32'h0040_0024);
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    chk("rst2.bcnt", 32'(bus.branch_cnt), 32'd0);
    chk("rst2.mcnt", 32'(bus.mispredict_cnt), 32'd0);
    look("rst2.a", 32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
    look("rst2.b", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
    look("wrap",   32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 32, the width of every PC and target address.
REQ-002 SHALL have parameter ENTRIES, default 16, the table depth; it must be a power of two and at least 2, else elaboration fails.
REQ-003 SHALL have parameter CNT_WIDTH, default 2, the width of each saturating direction counter (at least 1).
REQ-004 SHALL have parameter STAT_WIDTH, default 32, the width of each statistics counter.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port if_pc, input, ADR_WIDTH, the fetch-stage PC being looked up.
REQ-008 SHALL have port pred_hit, output, 1, set when a valid entry matches if_pc.
REQ-009 SHALL have port pred_taken, output, 1, the predicted branch direction for if_pc.
REQ-010 SHALL have port pred_next_pc, output, ADR_WIDTH, the predicted next fetch PC.
REQ-011 SHALL have port upd_valid, input, 1, marking a branch resolved in EX this cycle.
REQ-012 SHALL have ports upd_pc, upd_target, upd_pred_next_pc, each input, ADR_WIDTH: the branch PC, its resolved target, and the prediction carried down the pipeline.
REQ-013 SHALL have ports upd_taken and upd_pred_taken, each input, 1: the resolved direction and the predicted direction.
REQ-014 SHALL have port mispredict, output, 1, requesting a flush of IF/ID and ID/EX.
REQ-015 SHALL have port redirect_pc, output, ADR_WIDTH, the correct next PC on a mispredict.
REQ-016 SHALL have ports branch_cnt and mispredict_cnt, each output, STAT_WIDTH, the statistics counters.

Function
REQ-017 Table fields SHALL be as follows: index = pc[IDX+1:2] with IDX = log2(ENTRIES); tag = pc[ADR_WIDTH-1:IDX+2]; each entry holds valid, tag, target and counter.
REQ-018 Lookup SHALL be combinational and zero-latency:
- pred_hit = valid && tag match;
- pred_taken = pred_hit && counter MSB;
- pred_next_pc = pred_taken ? target : if_pc+4, modulo 2^ADR_WIDTH.
REQ-019 mispredict SHALL be combinational: upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_next_pc)).
REQ-020 redirect_pc SHALL equal upd_taken ? upd_target : upd_pc+4 whenever upd_valid is high; otherwise it is don't-care.
REQ-021 When upd_valid hits an entry, the counter SHALL increment if taken and decrement if not taken, saturating at all-ones and at zero; target is written only when taken.
REQ-022 When upd_valid misses and upd_taken is high, the entry SHALL be allocated or overwritten with valid=1, the new tag, upd_target, and counter = weakly taken (MSB 1, rest 0).
REQ-023 When upd_valid misses and upd_taken is low, the table SHALL be unchanged.
REQ-024 If lookup and update address the same index in one cycle, lookup SHALL return the pre-update contents (read-before-write); the new contents are visible from the next cycle.
REQ-025 branch_cnt SHALL increment on every upd_valid; mispredict_cnt SHALL increment when mispredict is high; both saturate at all-ones with no wrap.
REQ-026 With upd_valid low, no state SHALL change.

Reset
REQ-027 While rst is low at a clk edge, all valid bits SHALL clear, all counters load weakly not-taken (MSB 0, rest 1), and branch_cnt and mispredict_cnt load 0.
REQ-028 Reset SHALL take priority over a simultaneous update, and an update in flight is discarded.
REQ-029 While the table is reset, outputs SHALL be pred_hit=0, pred_taken=0 and pred_next_pc=if_pc+4; target and tag storage need not be cleared.

Structure
REQ-030 The shared package SHALL hold the default ADR_WIDTH, the counter-state constants (weak/strong taken and not-taken, expressed for CNT_WIDTH) and the PC increment constant 4.
REQ-031 The saturating-counter update SHALL be one sub-module, sat_counter, parametrised by CNT_WIDTH, with inputs cnt and taken and output next.
REQ-032 Table storage SHALL be flip-flops, with no memory macro.

Verification
REQ-033 Cold lookup: after reset, if_pc=0x0040_0010 -> pred_hit=0, pred_taken=0, pred_next_pc=0x0040_0014.
REQ-034 Allocate on taken miss: update pc 0x0040_0010, target 0x0040_0100, taken=1, pred_taken=0 -> mispredict=1, redirect_pc=0x0040_0100; next cycle the same lookup gives hit=1, taken=1, next_pc=0x0040_0100.
REQ-035 Counter saturation: four more taken updates leave the counter at 11; three not-taken updates give 00 and pred_taken=0; the first two of those three flag mispredict.
REQ-036 Aliasing: pc 0x0040_0010 allocated, then a taken update at 0x0040_0050 (same index, ENTRIES=16) -> lookup at 0x0040_0010 gives hit=0.
REQ-037 Same-cycle read/write: a lookup and update on one index in the same cycle -> lookup shows the old entry; the next cycle shows the new entry.
REQ-038 Reset mid-run and statistics: with STAT_WIDTH=4, 20 updates -> branch_cnt=15 (saturated); assert rst=0 for one cycle -> both counters 0 and all lookups miss.
